mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage between EX/MEM register and MEMWB register. Executes loads/stores
//  against a data-memory bus with a req/ready handshake, aligns and extends load data,
//  and produces the RegWrite/MemtoReg/data/ALUResult/rd bundle consumed by MEMWB.
//  Stalls the upstream pipeline while a memory transaction is outstanding.
// PARAMETERS
//  AW  32  byte-address width of mem_addr_o
//  DW  32  data width; fixed at 32, other values unsupported
// PORTS
//  clk            in   1   pipeline clock
//  rst_n          in   1   asynchronous reset, active-low
//  in_valid       in   1   EX/MEM bundle valid this cycle
//  MemRead_i      in   1   load op
//  MemWrite_i     in   1   store op (MemRead_i & MemWrite_i together = illegal, no access)
//  RegWrite_i     in   1   writeback enable
//  MemtoReg_i     in   1   writeback selects load data
//  funct3_i       in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResult_i    in   32  effective address / ALU result
//  wdata_i        in   32  store data (rs2)
//  rd_i           in   5   destination register
//  stall_o        out  1   upstream must hold its inputs
//  mem_req_o      out  1   bus request, held until mem_ready_i
//  mem_we_o       out  1   1 = write
//  mem_addr_o     out  AW  word-aligned address (bits[1:0]=00)
//  mem_be_o       out  4   byte enables
//  mem_wdata_o    out  32  lane-replicated store data
//  mem_ready_i    in   1   transaction complete; mem_rdata_i valid same cycle
//  mem_rdata_i    in   32  raw word read data
//  out_valid_o    out  1   bundle below valid for MEMWB this cycle
//  RegWrite_o, MemtoReg_o  out 1 each; data_o, ALUResult_o out 32 each; rd_o out 5
//  misalign_o     out  1   misaligned access flagged (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; mem_req_o deasserts immediately (async).
//  - FSM IDLE/BUS/DONE. IDLE: in_valid & no mem op -> register bundle, out_valid_o=1
//    next cycle, data_o=0 (latency 1). in_valid & mem op -> latch bundle, go BUS.
//  - stall_o = (state!=IDLE) | (state==IDLE & in_valid & (MemRead_i|MemWrite_i)).
//  - BUS: mem_req_o=1, addr/we/be/wdata stable; on mem_ready_i=1 capture extended read
//    data, go DONE. Ready may arrive in first BUS cycle (min mem latency 2 cycles).
//  - DONE: out_valid_o=1 for exactly one cycle, stall_o=0; return to IDLE, and the same
//    cycle's in_valid is NOT accepted (accepted next cycle; no back-to-back from DONE).
//  - Stores: out RegWrite_o=0 regardless of RegWrite_i. Illegal funct3 (011,110,111) or
//    Read&Write: no bus access, 1-cycle pass-through, RegWrite_o=0, data_o=0.
//  - be: B -> 4'b0001<<addr[1:0]; H -> addr[1]?1100:0011; W -> 1111.
//    mem_wdata_o: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
//  - Load extend: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
//  - out_valid_o=0 cycles: other outputs hold last value (MEMWB samples on valid only).
//  - Reset mid-BUS: transaction abandoned, no output produced.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> no bus
//   access, 1-cycle pass-through, RegWrite_o=0, misalign_o=1 with out_valid_o.
//  Undefined: misalign_o tied 0; low address bits ignored (H uses addr[1], W uses none).
// STRUCTURE
//  mem_stage_pkg: funct3 size codes, FSM state enum, BE constants.
//  Sub-module load_extend (combinational: rdata, addr[1:0], funct3 -> 32b result).
// TESTING
//  - LW addr 0x100, ready after 3 cycles, rdata 0xDEADBEEF -> data_o=0xDEADBEEF, stall 4 cyc.
//  - LB addr 0x103, rdata 0x80FF_0000 -> data_o=0xFFFFFF80; LBU -> 0x00000080.
//  - SH addr 0x202 wdata 0x1234ABCD -> be=1100, wdata_o=0xABCDABCD, RegWrite_o=0.
//  - ADD bundle rd=5, ALUResult 0x7 -> next cycle out_valid_o=1, rd_o=5, no mem_req_o.
//  - rst_n low during BUS -> mem_req_o=0 at once, out_valid_o stays 0, FSM IDLE.
//  - MEM_MISALIGN_TRAP_EN: LW addr 0x102 -> misalign_o=1, no mem_req_o, RegWrite_o=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 size codes, FSM states,
// byte-enable constants and small lane helpers.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic funct3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords pick their lane from addr[1] only; words always cover all lanes.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            SZ_B:    be = BE_BYTE << off;
            SZ_H:    be = off[1] ? BE_HALF_HI : BE_HALF_LO;
            SZ_W:    be = BE_WORD;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (f3[1:0])
            SZ_B:    lanes = {4{wdata[7:0]}};
            SZ_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            SZ_H:    mis = off[0];
            SZ_W:    mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Combinational load aligner: picks the addressed byte/halfword lane out of the
// raw bus word and sign- or zero-extends it according to funct3.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select followed by extension.
    always_comb begin
        case (offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_s[7]}}, byte_s};
            F3_H:    result = {{16{half_s[15]}}, half_s};
            F3_W:    result = rdata;
            F3_BU:   result = {24'h000000, byte_s};
            F3_HU:   result = {16'h0000, half_s};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ready data bus and emits the MEMWB bundle.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into flagged pass-throughs.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          MemRead_i,
    input  logic          MemWrite_i,
    input  logic          RegWrite_i,
    input  logic          MemtoReg_i,
    input  logic [2:0]    funct3_i,
    input  logic [31:0]   ALUResult_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [4:0]    rd_i,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [3:0]    mem_be_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ready_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          out_valid_o,
    output logic          RegWrite_o,
    output logic          MemtoReg_o,
    output logic [DW-1:0] data_o,
    output logic [31:0]   ALUResult_o,
    output logic [4:0]    rd_o,
    output logic          misalign_o
);

    state_e state_r;
    state_e state_nx_s;

    logic is_mem_s;
    logic illegal_s;
    logic misalign_s;
    logic bus_go_s;
    logic accept_s;
    logic stall_s;

    logic          req_r;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [3:0]    be_r;
    logic [31:0]   wdata_r;
    logic [2:0]    f3_r;
    logic [1:0]    off_r;

    logic        pend_regwrite_r;
    logic        pend_memtoreg_r;
    logic [31:0] pend_alu_r;
    logic [4:0]  pend_rd_r;

    logic        out_valid_r;
    logic        regwrite_r;
    logic        memtoreg_r;
    logic        misalign_r;
    logic [31:0] data_r;
    logic [31:0] alu_r;
    logic [4:0]  rd_r;

    logic [31:0] load_ext_s;

    load_extend u_load_extend (
        .rdata  (mem_rdata_i),
        .offset (off_r),
        .funct3 (f3_r),
        .result (load_ext_s)
    );

    // Classify the incoming bundle.
    always_comb begin
        is_mem_s  = MemRead_i | MemWrite_i;
        illegal_s = (MemRead_i & MemWrite_i) | ~funct3_legal(funct3_i);
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_s = is_mem_s & ~illegal_s & is_misaligned(funct3_i, ALUResult_i[1:0]);
`else
        misalign_s = 1'b0;
`endif
        bus_go_s = is_mem_s & ~illegal_s & ~misalign_s;
        accept_s = (state_r == ST_IDLE) & in_valid;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Illegal/misaligned memory ops go through DONE so the held bundle is consumed exactly once.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mem_s) begin
                    state_nx_s = bus_go_s ? ST_BUS : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (mem_ready_i) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUS;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Stall is released in DONE so upstream advances past the completed bundle.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = in_valid & is_mem_s;
            ST_BUS:  stall_s = 1'b1;
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Bus request registers and MEMWB bundle registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r           <= 1'b0;
            we_r            <= 1'b0;
            addr_r          <= {AW{1'b0}};
            be_r            <= 4'b0000;
            wdata_r         <= 32'h0000_0000;
            f3_r            <= 3'b000;
            off_r           <= 2'b00;
            pend_regwrite_r <= 1'b0;
            pend_memtoreg_r <= 1'b0;
            pend_alu_r      <= 32'h0000_0000;
            pend_rd_r       <= 5'd0;
            out_valid_r     <= 1'b0;
            regwrite_r      <= 1'b0;
            memtoreg_r      <= 1'b0;
            misalign_r      <= 1'b0;
            data_r          <= 32'h0000_0000;
            alu_r           <= 32'h0000_0000;
            rd_r            <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && bus_go_s) begin
                        req_r           <= 1'b1;
                        we_r            <= MemWrite_i;
                        addr_r          <= {ALUResult_i[AW-1:2], 2'b00};
                        be_r            <= byte_enable(funct3_i, ALUResult_i[1:0]);
                        wdata_r         <= store_lanes(funct3_i, wdata_i);
                        f3_r            <= funct3_i;
                        off_r           <= ALUResult_i[1:0];
                        pend_regwrite_r <= MemRead_i & RegWrite_i;
                        pend_memtoreg_r <= MemtoReg_i;
                        pend_alu_r      <= ALUResult_i;
                        pend_rd_r       <= rd_i;
                        out_valid_r     <= 1'b0;
                    end else if (accept_s) begin
                        out_valid_r <= 1'b1;
                        regwrite_r  <= is_mem_s ? 1'b0 : RegWrite_i;
                        memtoreg_r  <= MemtoReg_i;
                        misalign_r  <= misalign_s;
                        data_r      <= 32'h0000_0000;
                        alu_r       <= ALUResult_i;
                        rd_r        <= rd_i;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_BUS: begin
                    if (mem_ready_i) begin
                        req_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        regwrite_r  <= pend_regwrite_r;
                        memtoreg_r  <= pend_memtoreg_r;
                        misalign_r  <= 1'b0;
                        data_r      <= we_r ? 32'h0000_0000 : load_ext_s;
                        alu_r       <= pend_alu_r;
                        rd_r        <= pend_rd_r;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    out_valid_r <= 1'b0;
                end
                default: begin
                    req_r       <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o     = stall_s;
    assign mem_req_o   = req_r;
    assign mem_we_o    = we_r;
    assign mem_addr_o  = addr_r;
    assign mem_be_o    = be_r;
    assign mem_wdata_o = wdata_r;
    assign out_valid_o = out_valid_r;
    assign RegWrite_o  = regwrite_r;
    assign MemtoReg_o  = memtoreg_r;
    assign data_o      = data_r;
    assign ALUResult_o = alu_r;
    assign rd_o        = rd_r;
    assign misalign_o  = misalign_r;

endmodule
